regfile_read_arbiter: RTL and testbench

Shares the register file's single 32-entry read port, the 5-bit select feeding the bit-slice mux trees, between several requesters. Typical requesters are decode operand fetch, the debug/scan reader and the trap handler. Arbitration is round-robin, the port is pipelined at one grant per cycle, and read data is returned through a registered response tagged with the winning requester's ID.

---
 rtl/rfarb_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/regfile_read_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfarb_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package rfarb_pkg;

  localparam int unsigned RF_ADDR_W       = 5;
  localparam int unsigned RF_DATA_W       = 32;
  localparam int unsigned NUM_REQ_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rfarb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned j;
      // ptr_i < N and off < N, so one subtraction is enough to wrap.
      j = 32'(ptr_i) + off;
      if (j >= N) j = j - N;
      if (!valid_o && eligible_i[j[IW-1:0]]) begin
        valid_o            = 1'b1;
        idx_o              = j[IW-1:0];
        gnt_o[j[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the register file read port; two-stage registered response.
// Optional port locking is enabled by defining RFARB_LOCK_EN.
module regfile_read_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*RF_ADDR_W-1:0]   addr,
`ifdef RFARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             lock,
`endif
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           rf_busy,
  output logic [RF_ADDR_W-1:0]           rf_sel,
  input  logic [RF_DATA_W-1:0]           rf_rdata,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [RF_DATA_W-1:0]           rsp_data
);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   mask;
  logic [NUM_REQ-1:0]   eligible;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_valid;
  logic [RF_ADDR_W-1:0] gnt_addr;

  logic                 s1_valid_q;
  logic [ID_W-1:0]      s1_id_q;
  logic [RF_ADDR_W-1:0] sel_q;
  logic                 rsp_valid_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [RF_DATA_W-1:0] rsp_data_q;

  function automatic logic [ID_W-1:0] incr(input logic [ID_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef RFARB_LOCK_EN
  rfarb_state_t    state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;

  always_comb begin
    mask = '1;
    if (state_q == LOCKED) mask = NUM_REQ'(1) << owner_q;
  end

  // ptr stays frozen while locked and resumes just past the owner on release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ptr_d = incr(gnt_idx);
          if (lock[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        if (!lock[owner_q]) begin
          state_d = IDLE;
          ptr_d   = incr(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  assign mask = '1;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = incr(gnt_idx);
  end
`endif

  assign eligible = req & mask & {NUM_REQ{rst_n & ~rf_busy}};

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .idx_o      (gnt_idx),
    .valid_o    (gnt_valid)
  );

  assign gnt_addr = addr[32'(gnt_idx) * RF_ADDR_W +: RF_ADDR_W];

  // rf_busy only gates new grants; S1 and S2 always advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_valid;
      if (gnt_valid) begin
        sel_q   <= gnt_addr;
        s1_id_q <= gnt_idx;
      end
      rsp_valid_q <= s1_valid_q;
      rsp_id_q    <= s1_id_q;
      rsp_data_q  <= rf_rdata;
    end
  end

  assign rf_sel    = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed and random checks of regfile_read_arbiter against a behavioural model.
module tb_regfile_read_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rf_busy = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*5-1:0] addr = '0;
  logic [N-1:0]   gnt;
  logic [4:0]     rf_sel;
  logic [31:0]    rf_rdata;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;
  logic [31:0]    rf_mem [32];

  assign rf_rdata = rf_mem[rf_sel];

  always #5 clk = ~clk;

  regfile_read_arbiter #(
    .NUM_REQ (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
`ifdef RFARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rf_busy   (rf_busy),
    .rf_sel    (rf_sel),
    .rf_rdata  (rf_rdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model state.
  bit          m_known = 1'b0;
  int          m_ptr = 0;
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  int          m_sel = 0;
  bit          h_v = 1'b0;
  int          h_id = 0;
  bit          m_rv = 1'b0;
  int          m_rid = 0;
  bit          m_id_chk = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          eg_v;
  int          eg_id;
  bit          last_gv = 1'b0;
  int          last_gid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input int a);
    addr[i*5 +: 5] = 5'(a);
  endtask

  task automatic model_pick();
    eg_v  = 1'b0;
    eg_id = 0;
    if (rst_n && !rf_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!eg_v && req[i] && (!m_locked || i == m_owner)) begin
          eg_v  = 1'b1;
          eg_id = i;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_pick();
    chk("gnt", 32'(gnt), eg_v ? (32'd1 << eg_id) : 32'd0);
    if (m_known) begin
      chk("rf_sel", 32'(rf_sel), 32'(m_sel));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv || m_id_chk) chk("rsp_id", 32'(rsp_id), 32'(m_rid));
      chk("rsp_data", rsp_data, m_rdata);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known  = 1'b1;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_sel    = 0;
      h_v      = 1'b0;
      m_rv     = 1'b0;
      m_rid    = 0;
      m_rdata  = '0;
      m_id_chk = 1'b1;
    end else begin
      m_rdata  = rf_mem[m_sel];
      m_rv     = h_v;
      m_rid    = h_id;
      m_id_chk = 1'b0;
      h_v      = eg_v;
      h_id     = eg_id;
      if (eg_v) m_sel = int'(addr[eg_id*5 +: 5]);
      if (m_locked) begin
        if (!lock[m_owner]) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
        end
      end else if (eg_v) begin
        m_ptr = (eg_id + 1) % N;
        if (lock[eg_id]) begin
          m_locked = 1'b1;
          m_owner  = eg_id;
        end
      end
    end
    last_gv  = eg_v;
    last_gid = eg_id;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf_mem[k] = 32'(k) * 32'h11;

    // Reset.
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Single request: addr 7 -> data 0x77 two cycles after grant.
    req = 4'b0001;
    set_addr(0, 7);
    cycle();
    req = 4'b0000;
    repeat (3) cycle();

    // Move ptr to 0, then all four requesting continuously.
    req = 4'b1000;
    set_addr(3, 3);
    cycle();
    for (int i = 0; i < N; i++) set_addr(i, 10 + i);
    req = 4'b1111;
    repeat (5) cycle();
    req = 4'b0000;
    repeat (2) cycle();

    // rf_busy suppresses grants, ptr holds.
    req = 4'b0110;
    rf_busy = 1'b1;
    repeat (3) cycle();
    rf_busy = 1'b0;
    cycle();
    req = 4'b0100;
    cycle();
    req = 4'b0000;
    repeat (2) cycle();

    // Reset between grant and response drops the response.
    req = 4'b0001;
    set_addr(0, 5);
    cycle();
    req = 4'b0010;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req = 4'b0000;
    repeat (2) cycle();
    req = 4'b0011;
    set_addr(1, 9);
    cycle();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    repeat (2) cycle();

    // Wrap-around from ptr=3.
    req = 4'b0100;
    cycle();
    req = 4'b1001;
    set_addr(3, 30);
    set_addr(0, 31);
    cycle();
    req = 4'b0001;
    cycle();
    req = 4'b0000;
    repeat (2) cycle();

`ifdef RFARB_LOCK_EN
    // Lock by requester 2 excludes the others until released.
    req = 4'b0010;
    cycle();
    req = 4'b1111;
    lock = 4'b0100;
    repeat (4) cycle();
    lock = 4'b0000;
    repeat (2) cycle();
    req = 4'b0000;
    repeat (2) cycle();
`endif

    // Randomized traffic with requesters holding until granted.
    for (int k = 0; k < 32; k++) rf_mem[k] = $urandom;
    repeat (1500) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      rf_busy = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (last_gv && last_gid == i)) begin
          req[i] = ($urandom_range(0, 2) != 0);
          set_addr(i, int'($urandom_range(0, 31)));
        end
      end
`ifdef RFARB_LOCK_EN
      lock = 4'($urandom) & 4'($urandom);
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
